// File: rtl/cipher_text_plotter_pkg.sv
// Shared types and constants for the text plotter: screen geometry, FSM states, request encoding.
// Pure declarations; no latency or backpressure of its own.
package cipher_text_pkg;

  localparam int COLS_DEFAULT = 20;
  localparam int ROWS_DEFAULT = 15;
  localparam int GLYPH        = 8;

  localparam logic [7:0] CHAR_CR         = 8'h0D;
  localparam logic [7:0] FIRST_PRINTABLE = 8'h20;
  localparam logic [7:0] LAST_PRINTABLE  = 8'h7E;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ACCEPT,
    ST_FETCH,
    ST_WAIT,
    ST_DRAW,
    ST_ADVANCE
  } state_t;

  typedef enum logic {
    REQ_CHAR = 1'b0,
    REQ_DEL  = 1'b1
  } req_kind_t;

  typedef struct packed {
    req_kind_t  kind;
    logic [7:0] code;
  } req_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= FIRST_PRINTABLE) && (c <= LAST_PRINTABLE);
  endfunction

  function automatic logic [9:0] font_addr(input logic [7:0] c, input logic [2:0] r);
    logic [7:0] idx;
    idx = c - FIRST_PRINTABLE;
    return {idx[6:0], r};
  endfunction

endpackage

// File: rtl/cipher_text_plotter_if.sv
// Character request inputs and VGA pixel write port of the text plotter.
// master = plotter side, slave = datapath/adapter side.
interface cipher_text_plotter_if;
  logic       go_signal;
  logic [7:0] asciis;
  logic       del_signal;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       dropped;

  modport master (
    input  go_signal, asciis, del_signal,
    output x, y, colour, plot, busy, dropped
  );

  modport slave (
    output go_signal, asciis, del_signal,
    input  x, y, colour, plot, busy, dropped
  );
endinterface

// File: rtl/cipher_text_plotter_font_rom_8x8.sv
// 768x8 glyph ROM, one-cycle registered read, bit 7 = leftmost pixel; always ready.
// Digits and letters (lowercase shares the uppercase shapes); other printables render as a box.
module font_rom_8x8 (
  input  logic       clk,
  input  logic [9:0] addr,
  output logic [7:0] data
);

  logic [63:0] glyph;

  always_comb begin
    glyph = 64'h7E42424242427E00;
    case (addr[9:3])
      7'h00:        glyph = 64'h0000000000000000;
      7'h10:        glyph = 64'h3C666E7666663C00;
      7'h11:        glyph = 64'h1818381818187E00;
      7'h12:        glyph = 64'h3C66060C30607E00;
      7'h13:        glyph = 64'h3C66061C06663C00;
      7'h14:        glyph = 64'h060E1E667F060600;
      7'h15:        glyph = 64'h7E607C0606663C00;
      7'h16:        glyph = 64'h3C66607C66663C00;
      7'h17:        glyph = 64'h7E660C1818181800;
      7'h18:        glyph = 64'h3C66663C66663C00;
      7'h19:        glyph = 64'h3C66663E06663C00;
      7'h21, 7'h41: glyph = 64'h183C66667E666600;
      7'h22, 7'h42: glyph = 64'h7C66667C66667C00;
      7'h23, 7'h43: glyph = 64'h3C66606060663C00;
      7'h24, 7'h44: glyph = 64'h786C6666666C7800;
      7'h25, 7'h45: glyph = 64'h7E60607860607E00;
      7'h26, 7'h46: glyph = 64'h7E60607860606000;
      7'h27, 7'h47: glyph = 64'h3C66606E66663C00;
      7'h28, 7'h48: glyph = 64'h6666667E66666600;
      7'h29, 7'h49: glyph = 64'h3C18181818183C00;
      7'h2A, 7'h4A: glyph = 64'h1E0C0C0C0CCC7800;
      7'h2B, 7'h4B: glyph = 64'h666C7870786C6600;
      7'h2C, 7'h4C: glyph = 64'h6060606060607E00;
      7'h2D, 7'h4D: glyph = 64'h63777F6B63636300;
      7'h2E, 7'h4E: glyph = 64'h66767E7E6E666600;
      7'h2F, 7'h4F: glyph = 64'h3C66666666663C00;
      7'h30, 7'h50: glyph = 64'h7C66667C60606000;
      7'h31, 7'h51: glyph = 64'h3C666666663C0E00;
      7'h32, 7'h52: glyph = 64'h7C66667C786C6600;
      7'h33, 7'h53: glyph = 64'h3C66603C06663C00;
      7'h34, 7'h54: glyph = 64'h7E18181818181800;
      7'h35, 7'h55: glyph = 64'h6666666666663C00;
      7'h36, 7'h56: glyph = 64'h66666666663C1800;
      7'h37, 7'h57: glyph = 64'h6363636B7F776300;
      7'h38, 7'h58: glyph = 64'h66663C183C666600;
      7'h39, 7'h59: glyph = 64'h6666663C18181800;
      7'h3A, 7'h5A: glyph = 64'h7E060C1830607E00;
      default:      glyph = 64'h7E42424242427E00;
    endcase
  end

  always_ff @(posedge clk) begin
    data <= glyph[(7 - int'(addr[2:0])) * 8 +: 8];
  end

endmodule

// File: rtl/cipher_text_plotter.sv
// Renders one 8x8 glyph per go_signal rise (or blanks one cell per delete) into a 160x120 frame, one pixel/cycle.
// Input edge reaches the 1-deep buffer after 3 cycles; a request arriving with the buffer full is dropped (sticky flag).
module cipher_text_plotter
  import cipher_text_pkg::*;
#(
  parameter int         COLS = COLS_DEFAULT,
  parameter int         ROWS = ROWS_DEFAULT,
  parameter logic [2:0] FG   = 3'b111,
  parameter logic [2:0] BG   = 3'b000
) (
  input logic                   clk,
  input logic                   reset,
  cipher_text_plotter_if.master bus
);

  localparam logic [4:0] COL_LAST = 5'(COLS - 1);
  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);

  logic [2:0] go_sync, del_sync;
  logic       go_rise, del_fall;
  req_t       buf_q, cur;
  logic       buf_vld, pop, dropped;
  state_t     state;
  logic       blank;
  logic [2:0] r, px;
  logic [4:0] col;
  logic [3:0] row, row_next;
  logic [7:0] sr, rom_data, x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q;

  // [0],[1] are the synchronizer, [2] is the edge-detect history
  assign go_rise  = go_sync[1] & ~go_sync[2];
  assign del_fall = ~del_sync[1] & del_sync[2];
  assign pop      = (state == ST_IDLE) && buf_vld;
  assign row_next = (row == ROW_LAST) ? 4'd0 : row + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      go_sync  <= '0;
      del_sync <= '0;
    end else begin
      go_sync  <= {go_sync[1:0], bus.go_signal};
      del_sync <= {del_sync[1:0], bus.del_signal};
    end
  end

  // A char and a delete on the same cycle: the char wins, the delete counts as overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_vld <= 1'b0;
      buf_q   <= '0;
      dropped <= 1'b0;
    end else begin
      if (go_rise && del_fall) dropped <= 1'b1;
      if (go_rise || del_fall) begin
        if (buf_vld && !pop) begin
          dropped <= 1'b1;
        end else begin
          buf_vld <= 1'b1;
          buf_q   <= '{kind: (go_rise ? REQ_CHAR : REQ_DEL), code: bus.asciis};
        end
      end else if (pop) begin
        buf_vld <= 1'b0;
      end
    end
  end

  font_rom_8x8 u_font_rom (
    .clk  (clk),
    .addr (font_addr(cur.code, r)),
    .data (rom_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_CLEAR;
      cur      <= '0;
      blank    <= 1'b0;
      r        <= '0;
      px       <= '0;
      col      <= '0;
      row      <= '0;
      sr       <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= BG;
      plot_q   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (!plot_q) begin
            plot_q <= 1'b1;
          end else if (x_q == 8'd159) begin
            x_q <= '0;
            if (y_q == 7'd119) begin
              y_q    <= '0;
              plot_q <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              y_q <= y_q + 7'd1;
            end
          end else begin
            x_q <= x_q + 8'd1;
          end
        end
        ST_IDLE: begin
          if (buf_vld) begin
            cur   <= buf_q;
            state <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          r     <= '0;
          blank <= 1'b0;
          if (cur.kind == REQ_CHAR) begin
            if (is_printable(cur.code))  state <= ST_FETCH;
            else if (cur.code == CHAR_CR) state <= ST_ADVANCE;
            else                          state <= ST_IDLE;
          end else if (col == 5'd0 && row == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            blank <= 1'b1;
            state <= ST_FETCH;
            if (col == 5'd0) begin
              col <= COL_LAST;
              row <= row - 4'd1;
            end else begin
              col <= col - 5'd1;
            end
          end
        end
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          state    <= ST_DRAW;
          plot_q   <= 1'b1;
          px       <= '0;
          x_q      <= {col, 3'b000};
          y_q      <= {row, r};
          colour_q <= (!blank && rom_data[7]) ? FG : BG;
          sr       <= blank ? 8'h00 : {rom_data[6:0], 1'b0};
        end
        ST_DRAW: begin
          if (px == 3'd7) begin
            plot_q   <= 1'b0;
            colour_q <= BG;
            if (r == 3'd7) begin
              state <= ST_ADVANCE;
            end else begin
              r     <= r + 3'd1;
              state <= ST_FETCH;
            end
          end else begin
            px       <= px + 3'd1;
            x_q      <= x_q + 8'd1;
            colour_q <= sr[7] ? FG : BG;
            sr       <= {sr[6:0], 1'b0};
          end
        end
        ST_ADVANCE: begin
          state <= ST_IDLE;
          if (cur.kind == REQ_CHAR) begin
            if (cur.code == CHAR_CR || col == COL_LAST) begin
              col <= '0;
              row <= row_next;
            end else begin
              col <= col + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.colour  = colour_q;
  assign bus.plot    = plot_q;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.dropped = dropped;

endmodule
